// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared types and constants for the 16-bit pipeline front end.
// Optional macro: FETCH_BUS_ERR_EN adds a fault bit to each fetch entry.
// Revision: 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
`ifdef FETCH_BUS_ERR_EN
        logic        fault;
`endif
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : prefetch FIFO of {pc, instr} entries, DEPTH 1..4; flush beats push.
// Revision: 1.0
// ============================================================================
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t head,
    output logic [2:0]   count
);
    localparam logic [1:0] LAST_IDX = 2'(DEPTH - 1);
    localparam logic [2:0] FULL_CNT = 3'(DEPTH);

    // Storage is always four slots so 2-bit pointers index it cleanly for any DEPTH.
    fetch_entry_t slots [4];
    logic [1:0]   rd_ptr;
    logic [1:0]   wr_ptr;
    logic         do_pop;
    logic         do_push;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
    endfunction

    assign do_pop  = pop && (count != 3'd0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                slots[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= wr_entry;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : single-outstanding instruction fetch feeding decode via a prefetch FIFO.
// Optional macro: FETCH_BUS_ERR_EN adds mem_err / instr_fault and halts on bus error.
// Revision: 1.0
// ============================================================================
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
`ifdef FETCH_BUS_ERR_EN
    input  logic        mem_err,
    output logic        instr_fault,
`endif
    output logic        instr_valid,
    output logic [15:0] instr_out,
    output logic [15:0] pc_out
);
    localparam logic [2:0] DEPTH_CNT = 3'(FIFO_DEPTH);

    fetch_state_t state;
    fetch_state_t state_nx;
    logic [15:0]  fetch_pc;
    logic [15:0]  fetch_pc_nx;
    logic [15:0]  stale_addr;
    logic [15:0]  stale_addr_nx;
    logic         push;
    logic         pop;
    logic         flush;
    logic         can_issue;
    logic [2:0]   count;
    logic [2:0]   count_after_push;
    fetch_entry_t wr_entry;
    fetch_entry_t head;
`ifdef FETCH_BUS_ERR_EN
    logic         halted;
    logic         halted_nx;
`endif

    assign pop              = instr_valid && !stall;
    assign count_after_push = count + 3'd1 - {2'b00, pop};
`ifdef FETCH_BUS_ERR_EN
    assign can_issue = (count < DEPTH_CNT) && !halted;
`else
    assign can_issue = (count < DEPTH_CNT);
`endif

    always_comb begin
        state_nx       = state;
        fetch_pc_nx    = fetch_pc;
        stale_addr_nx  = stale_addr;
        push           = 1'b0;
        flush          = 1'b0;
        mem_req        = 1'b0;
        mem_addr       = fetch_pc;
        wr_entry       = '0;
        wr_entry.pc    = fetch_pc;
        wr_entry.instr = mem_rdata;
`ifdef FETCH_BUS_ERR_EN
        halted_nx      = halted;
`endif
        case (state)
            IDLE: begin
                if (can_issue) state_nx = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    push        = 1'b1;
                    fetch_pc_nx = fetch_pc + 16'd1;
                    state_nx    = (count_after_push < DEPTH_CNT) ? REQ : IDLE;
`ifdef FETCH_BUS_ERR_EN
                    if (mem_err) begin
                        wr_entry.instr = '0;
                        wr_entry.fault = 1'b1;
                        halted_nx      = 1'b1;
                        state_nx       = IDLE;
                    end
`endif
                end
            end
            DISCARD: begin
                // The memory still owns the pre-branch request; keep its address stable.
                mem_req  = 1'b1;
                mem_addr = stale_addr;
                if (mem_ack) state_nx = (count < DEPTH_CNT) ? REQ : IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (branch_taken) begin
            flush       = 1'b1;
            push        = 1'b0;
            fetch_pc_nx = branch_target;
`ifdef FETCH_BUS_ERR_EN
            halted_nx   = 1'b0;
`endif
            if (state == REQ && !mem_ack) begin
                state_nx      = DISCARD;
                stale_addr_nx = fetch_pc;
            end else if (state == DISCARD && !mem_ack) begin
                state_nx = DISCARD;
            end else begin
                state_nx = REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            stale_addr <= RESET_PC;
        end else begin
            state      <= state_nx;
            fetch_pc   <= fetch_pc_nx;
            stale_addr <= stale_addr_nx;
        end
    end

`ifdef FETCH_BUS_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halted <= 1'b0;
        else        halted <= halted_nx;
    end
`endif

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_entry (wr_entry),
        .head     (head),
        .count    (count)
    );

    assign instr_valid = (count != 3'd0);
    assign instr_out   = head.instr;
    assign pc_out      = head.pc;
`ifdef FETCH_BUS_ERR_EN
    assign instr_fault = instr_valid && head.fault;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage : scoreboard plus vector-table bench for fetch_stage.
// Revision: 1.0
// ============================================================================
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n, stall, branch_taken, ack_en;
    logic        mem_req, mem_ack, instr_valid;
    logic [15:0] branch_target, mem_addr, mem_rdata, instr_out, pc_out;
`ifdef FETCH_BUS_ERR_EN
    logic        mem_err, instr_fault, err_en;
    assign mem_err = err_en && (mem_addr == 16'h0004);
`endif

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_image(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    assign mem_ack   = ack_en & mem_req;
    assign mem_rdata = mem_image(mem_addr);

    fetch_stage #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
`ifdef FETCH_BUS_ERR_EN
        .mem_err       (mem_err),
        .instr_fault   (instr_fault),
`endif
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .instr_valid   (instr_valid),
        .instr_out     (instr_out),
        .pc_out        (pc_out)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } exp_t;

    typedef struct {
        logic        stall;
        logic        ack;
        logic        req;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] pc;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[11];
    int          checks = 0;
    int          errors = 0;
    int          n_consumed;
    logic        mon_en = 1'b0;
    logic        stale, after_branch, prev_pend;
    logic [15:0] exp_addr, stale_addr, prev_addr, last_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the fetch stream; expected entries queue on each live ack.
    task automatic monitor();
        exp_t e;
        if (!mon_en) return;
        if (prev_pend) begin
            chk("req_hold", mem_req, 1);
            chk("addr_hold", mem_addr, prev_addr);
        end
        if (after_branch) chk("valid_after_branch", instr_valid, 0);
        if (mem_req) chk("mem_addr", mem_addr, stale ? stale_addr : exp_addr);
        chk("valid_vs_sb", instr_valid, (sb.size() != 0));
        if (sb.size() > DEPTH) chk("sb_depth", sb.size(), DEPTH);
        if (instr_valid && !stall && !branch_taken) begin
            if (sb.size() == 0) begin
                chk("sb_empty_pop", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("pc_out", pc_out, e.pc);
                chk("instr_out", instr_out, e.instr);
                last_pc = pc_out;
                n_consumed++;
            end
        end
        if (branch_taken) begin
            sb.delete();
            if (mem_req && !mem_ack) begin
                if (!stale) stale_addr = exp_addr;
                stale = 1'b1;
            end else if (mem_req && mem_ack) begin
                stale = 1'b0;
            end
            exp_addr = branch_target;
        end else if (mem_req && mem_ack) begin
            if (stale) begin
                stale = 1'b0;
            end else begin
                sb.push_back('{pc: exp_addr, instr: mem_image(exp_addr)});
                exp_addr = exp_addr + 16'd1;
            end
        end
        after_branch = branch_taken;
        prev_pend    = mem_req && !mem_ack;
        prev_addr    = mem_addr;
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mon_en        = 1'b0;
        rst_n         = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        ack_en        = 1'b0;
`ifdef FETCH_BUS_ERR_EN
        err_en        = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, RST_PC);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr_out, 0);
        chk("rst_pc", pc_out, 0);
        adv();
        rst_n        = 1'b1;
        sb.delete();
        exp_addr     = RST_PC;
        stale        = 1'b0;
        after_branch = 1'b0;
        prev_pend    = 1'b0;
        n_consumed   = 0;
        mon_en       = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // {stall, ack, exp_req, exp_addr, exp_valid, exp_pc}
        vt[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0000};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000};
        vt[9]  = '{1'b0, 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0002};
        vt[10] = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0003};

        // Streaming with ack tied high: one entry per cycle from the second cycle on.
        do_reset();
        ack_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            sample();
            adv();
        end
        chk("stream_count", n_consumed, 10);
        chk("stream_last_pc", last_pc, 16'h0009);

        // Stall fills the FIFO, requests stop, release continues the PC sequence.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            stall  = vt[i].stall;
            ack_en = vt[i].ack;
            sample();
            chk($sformatf("vec%0d_req", i), mem_req, vt[i].req);
            if (vt[i].req) chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].addr);
            chk($sformatf("vec%0d_valid", i), instr_valid, vt[i].valid);
            if (vt[i].valid) chk($sformatf("vec%0d_pc", i), pc_out, vt[i].pc);
            adv();
        end

        // Branches during a slow ack: old address held, data dropped, latest target wins.
        do_reset();
        sample(); adv();
        sample(); chk("slow_req", mem_req, 1); chk("slow_addr", mem_addr, 16'h0000); adv();
        branch_taken = 1'b1; branch_target = 16'h0200;
        sample(); adv();
        branch_target = 16'h0100;
        sample(); chk("disc_req", mem_req, 1); chk("disc_addr", mem_addr, 16'h0000); adv();
        branch_taken = 1'b0; ack_en = 1'b1;
        sample(); chk("disc_ack_addr", mem_addr, 16'h0000); adv();
        ack_en = 1'b0;
        sample(); chk("tgt_addr", mem_addr, 16'h0100); chk("tgt_valid0", instr_valid, 0); adv();
        sample(); chk("tgt_valid1", instr_valid, 0); adv();
        ack_en = 1'b1;
        sample(); adv();
        ack_en = 1'b0; stall = 1'b1;
        sample(); chk("tgt_pc", pc_out, 16'h0100);
        chk("tgt_instr", instr_out, mem_image(16'h0100)); adv();

        // Branch in the same cycle as an ack and a consume.
        stall = 1'b0; ack_en = 1'b1;
        repeat (3) begin sample(); adv(); end
        branch_taken = 1'b1; branch_target = 16'h0300;
        sample(); chk("bac_valid_pre", instr_valid, 1); chk("bac_ack_pre", mem_ack, 1); adv();
        branch_taken = 1'b0;
        sample(); chk("bac_valid", instr_valid, 0); chk("bac_addr", mem_addr, 16'h0300); adv();
        repeat (4) begin sample(); adv(); end

        // Address wrap at 16'hFFFF.
        branch_taken = 1'b1; branch_target = 16'hFFFE;
        sample(); n_consumed = 0; adv();
        branch_taken = 1'b0;
        repeat (4) begin sample(); adv(); end
        chk("wrap_count", n_consumed, 3);
        chk("wrap_last_pc", last_pc, 16'h0000);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            stall         = ($urandom_range(0, 3) == 0);
            ack_en        = ($urandom_range(0, 2) != 0);
            branch_taken  = ($urandom_range(0, 19) == 0);
            branch_target = 16'($urandom);
            sample();
            adv();
        end
        branch_taken = 1'b0;

`ifdef FETCH_BUS_ERR_EN
        // Bus error at PC 4 halts fetch until the next branch.
        do_reset();
        mon_en = 1'b0;
        stall = 1'b1; ack_en = 1'b1; err_en = 1'b1;
        branch_taken = 1'b1; branch_target = 16'h0004;
        sample(); adv();
        branch_taken = 1'b0;
        sample(); chk("err_req", mem_req, 1); chk("err_addr", mem_addr, 16'h0004); adv();
        sample(); chk("err_valid", instr_valid, 1); chk("err_fault", instr_fault, 1);
        chk("err_pc", pc_out, 16'h0004); chk("err_instr", instr_out, 0); chk("err_halt0", mem_req, 0); adv();
        sample(); chk("err_halt1", mem_req, 0); adv();
        stall = 1'b0;
        sample(); adv();
        sample(); chk("err_empty", instr_valid, 0); chk("err_halt2", mem_req, 0);
        chk("err_fault_clr", instr_fault, 0); adv();
        branch_taken = 1'b1; branch_target = 16'h0010; err_en = 1'b0;
        sample(); adv();
        branch_taken = 1'b0;
        sample(); chk("rst_req", mem_req, 1); chk("rst_addr", mem_addr, 16'h0010); adv();
        stall = 1'b1;
        sample(); chk("rst_valid2", instr_valid, 1); chk("rst_pc2", pc_out, 16'h0010);
        chk("rst_fault", instr_fault, 0); adv();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
